// File: rtl/chip8_fb_if.sv
// CHIP-8 framebuffer arbiter bus: CPU pixel port, scanout port, clear control and RAM port.
// The slave modport is the arbiter; the master modport is its environment (requesters plus RAM).
interface chip8_fb_if;
  logic        cpu_req;
  logic [10:0] cpu_addr;
  logic        cpu_flip;
  logic        cpu_ack;
  logic        cpu_val;
  logic        scan_req;
  logic [10:0] scan_addr;
  logic        scan_ack;
  logic        scan_data;
  logic        clr_start;
  logic        clr_busy;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic        ram_wdata;
  logic        ram_rdata;

  modport slave (
    input  cpu_req, cpu_addr, cpu_flip, scan_req, scan_addr, clr_start, ram_rdata,
    output cpu_ack, cpu_val, scan_ack, scan_data, clr_busy, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output cpu_req, cpu_addr, cpu_flip, scan_req, scan_addr, clr_start, ram_rdata,
    input  cpu_ack, cpu_val, scan_ack, scan_data, clr_busy, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/chip8_fb_arbiter.sv
// CHIP-8 framebuffer arbiter: CPU read/XOR-flip, scanout read and full-screen clear on one 1-bit RAM.
// Define CHIP8_FB_SCAN_FAIR_EN for round-robin CPU/scan arbitration (default: CPU has strict priority).
module chip8_fb_arbiter #(
  parameter int FB_PIXELS = 2048
) (
  input  logic      clk,
  input  logic      reset,
  chip8_fb_if.slave bus
);
  localparam int AW = 11;
  localparam logic [AW-1:0] LAST_ADDR = AW'(FB_PIXELS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CPU_RD  = 3'd1,
    CPU_WR  = 3'd2,
    SCAN_RD = 3'd3,
    CLEAR   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          flip_q, flip_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          clr_pend_q, clr_pend_d;
  logic          scan_ack_q, scan_ack_d;
`ifdef CHIP8_FB_SCAN_FAIR_EN
  logic          last_cpu_q, last_cpu_d;
`endif

  logic scan_want;
  logic cpu_win;
  logic scan_win;
  logic clr_go;

  // Arbitration and next-state logic.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    flip_d     = flip_q;
    cnt_d      = cnt_q;
    clr_pend_d = clr_pend_q;
    scan_ack_d = 1'b0;
    clr_go     = clr_pend_q | bus.clr_start;
    // A scan request still high in its own ack cycle is the old request, not a new one.
    scan_want  = bus.scan_req & ~scan_ack_q;
`ifdef CHIP8_FB_SCAN_FAIR_EN
    last_cpu_d = last_cpu_q;
    cpu_win    = bus.cpu_req & (~scan_want | ~last_cpu_q);
`else
    cpu_win    = bus.cpu_req;
`endif
    scan_win   = scan_want & ~cpu_win;

    case (state_q)
      IDLE: begin
        if (clr_go) begin
          state_d    = CLEAR;
          clr_pend_d = 1'b0;
          cnt_d      = '0;
        end else if (cpu_win) begin
          state_d = CPU_RD;
          addr_d  = bus.cpu_addr;
          flip_d  = bus.cpu_flip;
`ifdef CHIP8_FB_SCAN_FAIR_EN
          last_cpu_d = 1'b1;
`endif
        end else if (scan_win) begin
          state_d = SCAN_RD;
          addr_d  = bus.scan_addr;
`ifdef CHIP8_FB_SCAN_FAIR_EN
          last_cpu_d = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      CPU_RD: begin
        state_d    = CPU_WR;
        clr_pend_d = clr_go;
      end
      CPU_WR: begin
        if (clr_go) begin
          state_d    = CLEAR;
          clr_pend_d = 1'b0;
          cnt_d      = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN_RD: begin
        state_d    = IDLE;
        scan_ack_d = 1'b1;
        clr_pend_d = clr_go;
      end
      CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched-request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= 11'd0;
      flip_q     <= 1'b0;
      cnt_q      <= 11'd0;
      clr_pend_q <= 1'b0;
      scan_ack_q <= 1'b0;
`ifdef CHIP8_FB_SCAN_FAIR_EN
      last_cpu_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      flip_q     <= flip_d;
      cnt_q      <= cnt_d;
      clr_pend_q <= clr_pend_d;
      scan_ack_q <= scan_ack_d;
`ifdef CHIP8_FB_SCAN_FAIR_EN
      last_cpu_q <= last_cpu_d;
`endif
    end
  end

  // RAM port and handshake outputs; reset forces everything quiet in the same cycle.
  always_comb begin
    bus.cpu_ack   = 1'b0;
    bus.cpu_val   = 1'b0;
    bus.scan_ack  = 1'b0;
    bus.scan_data = 1'b0;
    bus.clr_busy  = 1'b0;
    bus.ram_addr  = 11'd0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = 1'b0;
    if (reset) begin
      bus.ram_we = 1'b0;
    end else begin
      case (state_q)
        CPU_RD, SCAN_RD: begin
          bus.ram_addr = addr_q;
        end
        CPU_WR: begin
          bus.cpu_ack   = 1'b1;
          bus.cpu_val   = bus.ram_rdata;
          bus.ram_addr  = addr_q;
          bus.ram_we    = flip_q;
          bus.ram_wdata = flip_q & ~bus.ram_rdata;
        end
        CLEAR: begin
          bus.ram_addr = cnt_q;
          bus.ram_we   = 1'b1;
        end
        default: begin
          bus.ram_addr = 11'd0;
        end
      endcase
      bus.scan_ack  = scan_ack_q;
      bus.scan_data = scan_ack_q & bus.ram_rdata;
      bus.clr_busy  = (state_q == CLEAR) | clr_pend_q;
    end
  end
endmodule
